// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: controller
// state encoding, opcode/funct constants, ALU operation codes (also used by
// the ALU) and the datapath mux select encodings.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BEQ      = 4'd8,
      S_ADDI_EX  = 4'd9,
      S_ADDI_WB  = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLL = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SLT = 3'd6;

   localparam logic [1:0] SRCA_PC = 2'b00;
   localparam logic [1:0] SRCA_A  = 2'b01;
   localparam logic [1:0] SRCA_B  = 2'b10;

   localparam logic [2:0] SRCB_B      = 3'b000;
   localparam logic [2:0] SRCB_4      = 3'b001;
   localparam logic [2:0] SRCB_IMM    = 3'b010;
   localparam logic [2:0] SRCB_IMM_SH = 3'b011;
   localparam logic [2:0] SRCB_SHAMT  = 3'b100;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder.
//   i_funct    : IR[5:0]
//   o_aluop    : ALU operation for this funct (add when not valid)
//   o_is_shift : sll/srl, which take rt and shamt as ALU operands
//   o_valid    : funct is one of the supported R-type operations
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [2:0] o_aluop,
   output logic       o_is_shift,
   output logic       o_valid
);

   always_comb begin
      o_aluop    = ALU_ADD;
      o_is_shift = 1'b0;
      o_valid    = 1'b1;
      case (i_funct)
         FN_ADD:  o_aluop = ALU_ADD;
         FN_SUB:  o_aluop = ALU_SUB;
         FN_AND:  o_aluop = ALU_AND;
         FN_OR:   o_aluop = ALU_OR;
         FN_SLT:  o_aluop = ALU_SLT;
         FN_SLL:  begin o_aluop = ALU_SLL; o_is_shift = 1'b1; end
         FN_SRL:  begin o_aluop = ALU_SRL; o_is_shift = 1'b1; end
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit. Steps each instruction through its
// states and drives datapath selects/strobes plus the ALU operation.
//   clk, reset          : clock, async active-high reset
//   opcode, funct       : instruction register fields
//   zeroflag            : ALU equality flag, used only in BEQ
//   mem_ready           : memory access completes this cycle
//   aluop, alu_src_a/b, pc_src, iord, reg_dst, mem_to_reg : datapath selects
//   pc_en, ir_write, mem_read, mem_write, reg_write       : datapath strobes
//   illegal             : one-cycle pulse on an undecodable instruction
//   instr_count         : retired-instruction count (wraps)
//
// state      | meaning
// FETCH      | read instruction, PC+4 into PC when memory ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEMADR     | effective address rs + imm
// MEMRD      | data read, wait for memory
// MEMWB      | load data into rt
// MEMWR      | data write, wait for memory
// RTYPE_EX   | R-type ALU operation
// RTYPE_WB   | ALU result into rd
// BEQ        | compare rs/rt, PC <- ALUOut when equal
// ADDI_EX    | rs + imm
// ADDI_WB    | ALU result into rt
// JUMP       | PC <- jump target
module multicycle_control
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zeroflag,
   input  logic             mem_ready,
   output logic [2:0]       aluop,
   output logic [1:0]       alu_src_a,
   output logic [2:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic             pc_en,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   state_t           r_state;
   state_t           w_next;
   logic             r_is_sw;
   logic [CNT_W-1:0] r_count;

   logic [2:0] w_fn_aluop;
   logic       w_fn_shift;
   logic       w_fn_valid;
   logic       w_op_valid;
   logic       w_retire;

   logic w_pc_en, w_ir_write, w_mem_read, w_mem_write, w_reg_write, w_illegal;

   alu_decoder u_alu_decoder (
      .i_funct    (funct),
      .o_aluop    (w_fn_aluop),
      .o_is_shift (w_fn_shift),
      .o_valid    (w_fn_valid)
   );

   always_comb begin
      case (opcode)
         OP_RTYPE:                          w_op_valid = w_fn_valid;
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_valid = 1'b1;
         default:                           w_op_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            w_next = S_FETCH;
            if (w_op_valid) begin
               case (opcode)
                  OP_RTYPE:     w_next = S_RTYPE_EX;
                  OP_LW, OP_SW: w_next = S_MEMADR;
                  OP_BEQ:       w_next = S_BEQ;
                  OP_ADDI:      w_next = S_ADDI_EX;
                  default:      w_next = S_JUMP;
               endcase
            end
         end
         S_MEMADR:   w_next = r_is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:    if (mem_ready) w_next = S_MEMWB;
         S_MEMWR:    if (mem_ready) w_next = S_FETCH;
         S_RTYPE_EX: w_next = S_RTYPE_WB;
         S_ADDI_EX:  w_next = S_ADDI_WB;
         default:    w_next = S_FETCH;
      endcase
   end

   // Every state that can fall back to FETCH except DECODE retires an
   // instruction; DECODE only returns to FETCH for illegal encodings.
   assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                     (r_state != S_DECODE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_is_sw <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         // lw/sw choice is captured so MEMADR does not depend on opcode.
         if (r_state == S_DECODE) r_is_sw <= (opcode == OP_SW);
         if (w_retire) r_count <= r_count + CNT_W'(1);
      end
   end

   always_comb begin
      aluop       = ALU_ADD;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_B;
      pc_src      = PCSRC_ALU;
      iord        = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      w_pc_en     = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_illegal   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            alu_src_b  = SRCB_4;
            w_ir_write = mem_ready;
            w_pc_en    = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            w_illegal = ~w_op_valid;
         end
         S_MEMADR, S_ADDI_EX: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            iord       = 1'b1;
         end
         S_MEMWB: begin
            w_reg_write = 1'b1;
            mem_to_reg  = 1'b1;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            iord        = 1'b1;
         end
         S_RTYPE_EX: begin
            aluop     = w_fn_aluop;
            alu_src_a = w_fn_shift ? SRCA_B : SRCA_A;
            alu_src_b = w_fn_shift ? SRCB_SHAMT : SRCB_B;
         end
         S_RTYPE_WB: begin
            w_reg_write = 1'b1;
            reg_dst     = 1'b1;
         end
         S_BEQ: begin
            aluop     = ALU_SUB;
            alu_src_a = SRCA_A;
            pc_src    = PCSRC_ALUOUT;
            w_pc_en   = zeroflag;
         end
         S_ADDI_WB:  w_reg_write = 1'b1;
         S_JUMP: begin
            pc_src  = PCSRC_JUMP;
            w_pc_en = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are gated by reset directly so they drop without waiting a clock.
   assign pc_en       = w_pc_en     & ~reset;
   assign ir_write    = w_ir_write  & ~reset;
   assign mem_read    = w_mem_read  & ~reset;
   assign mem_write   = w_mem_write & ~reset;
   assign reg_write   = w_reg_write & ~reset;
   assign illegal     = w_illegal   & ~reset;
   assign instr_count = r_count;

endmodule
